// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: opcodes, FSM states,
// mux-select encodings and the control word driven by the decoder.
package ctrl_pkg;

    localparam int unsigned OPW    = 6;
    localparam int unsigned RA_IDX = 31;

    localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OPW-1:0] OP_AND   = 6'b010000;
    localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPW-1:0] OP_SLT   = 6'b100110;
    localparam logic [OPW-1:0] OP_SW    = 6'b110000;
    localparam logic [OPW-1:0] OP_LW    = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b110101;
    localparam logic [OPW-1:0] OP_J     = 6'b111000;
    localparam logic [OPW-1:0] OP_JR    = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
    localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_EXE_R = 4'd2,
        S_WB_R  = 4'd3,
        S_EXE_M = 4'd4,
        S_MEM   = 4'd5,
        S_WB_L  = 4'd6,
        S_EXE_B = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG    = 2'b11
    } pc_src_t;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_ALU,
        CL_LW,
        CL_SW,
        CL_BR,
        CL_JMP,
        CL_HALT
    } op_class_t;

    typedef struct packed {
        logic       pc_wre;
        logic [1:0] pc_src;
        logic       ir_wre;
        logic       reg_wre;
        logic [1:0] reg_dst;
        logic       wr_reg_d_src;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       ext_sel;
        logic       m_rd;
        logic       m_wr;
        logic       db_data_src;
    } ctrl_word_t;

    // Instruction class used by both sequencing and decode.
    function automatic op_class_t op_class(input logic [OPW-1:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ORI, OP_SLT: cls = CL_ALU;
            OP_LW:                                           cls = CL_LW;
            OP_SW:                                           cls = CL_SW;
            OP_BEQ, OP_BNE:                                  cls = CL_BR;
            OP_J, OP_JR, OP_JAL:                             cls = CL_JMP;
            OP_HALT:                                         cls = CL_HALT;
            default:                                         cls = CL_NOP;
        endcase
        return cls;
    endfunction

    function automatic logic is_rtype(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Pure combinational decode of (state, opcode, zero) into the datapath control word.
module multi_cycle_ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0]     state,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output ctrl_word_t     cw
);

    op_class_t cls;
    logic      taken;

    assign cls   = op_class(opcode);
    assign taken = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);

    always_comb begin
        cw = '0;

        // Opcode-only selects; harmless outside the states that consume them.
        if (opcode == OP_JAL) begin
            cw.reg_dst = RD_RA;
        end else if (is_rtype(opcode)) begin
            cw.reg_dst = RD_RD;
        end else begin
            cw.reg_dst = RD_RT;
        end
        cw.wr_reg_d_src = (opcode != OP_JAL);
        cw.alu_src_a    = 1'b0;
        cw.alu_src_b    = (opcode == OP_ADDIU) || (opcode == OP_ORI) ||
                          (opcode == OP_LW)    || (opcode == OP_SW);
        cw.ext_sel      = (opcode != OP_ORI);
        case (opcode)
            OP_SUB, OP_BEQ, OP_BNE: cw.alu_op = ALU_SUB;
            OP_AND:                 cw.alu_op = ALU_AND;
            OP_ORI:                 cw.alu_op = ALU_OR;
            OP_SLT:                 cw.alu_op = ALU_SLT;
            default:                cw.alu_op = ALU_ADD;
        endcase

        case (state)
            S_IF: begin
                cw.ir_wre = 1'b1;
            end
            S_ID: begin
                // Jumps and undefined opcodes retire here.
                if (cls == CL_JMP || cls == CL_NOP) begin
                    cw.pc_wre = 1'b1;
                    case (opcode)
                        OP_J:    cw.pc_src = PC_JUMP;
                        OP_JAL:  cw.pc_src = PC_JUMP;
                        OP_JR:   cw.pc_src = PC_REG;
                        default: cw.pc_src = PC_NEXT;
                    endcase
                    cw.reg_wre = (opcode == OP_JAL);
                end
            end
            S_WB_R: begin
                cw.pc_wre  = 1'b1;
                cw.reg_wre = 1'b1;
            end
            S_MEM: begin
                cw.m_wr   = (cls == CL_SW);
                cw.m_rd   = (cls == CL_LW);
                cw.pc_wre = (cls == CL_SW);
            end
            S_WB_L: begin
                cw.m_rd        = 1'b1;
                cw.db_data_src = 1'b1;
                cw.reg_wre     = 1'b1;
                cw.pc_wre      = 1'b1;
            end
            S_EXE_B: begin
                cw.pc_wre = 1'b1;
                cw.pc_src = taken ? PC_BRANCH : PC_NEXT;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Control unit FSM of the multi-cycle CPU: sequences IF/ID/EXE/MEM/WB per instruction
// and exposes the decoded control word on named ports.
module multi_cycle_ctrl
    import ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           PCWre,
    output logic [1:0]     PCSrc,
    output logic           IRWre,
    output logic           RegWre,
    output logic [1:0]     RegDst,
    output logic           WrRegDSrc,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic [2:0]     ALUOp,
    output logic           ExtSel,
    output logic           mRD,
    output logic           mWR,
    output logic           DBDataSrc,
    output logic [3:0]     state_o
);

    logic [3:0] state;
    logic [3:0] next_state;
    ctrl_word_t cw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IF;
        end else begin
            state <= next_state;
        end
    end

    // Illegal encodings fall through to S_IF.
    always_comb begin
        next_state = S_IF;
        case (state)
            S_IF:    next_state = S_ID;
            S_ID: begin
                case (op_class(opcode))
                    CL_ALU:       next_state = S_EXE_R;
                    CL_LW, CL_SW: next_state = S_EXE_M;
                    CL_BR:        next_state = S_EXE_B;
                    CL_HALT:      next_state = S_HALT;
                    default:      next_state = S_IF;
                endcase
            end
            S_EXE_R: next_state = S_WB_R;
            S_WB_R:  next_state = S_IF;
            S_EXE_M: next_state = S_MEM;
            S_MEM:   next_state = (opcode == OP_LW) ? S_WB_L : S_IF;
            S_WB_L:  next_state = S_IF;
            S_EXE_B: next_state = S_IF;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_IF;
        endcase
    end

    multi_cycle_ctrl_decode u_decode (
        .state  (state),
        .opcode (opcode),
        .zero   (zero),
        .cw     (cw)
    );

    assign PCWre     = cw.pc_wre;
    assign PCSrc     = cw.pc_src;
    assign IRWre     = cw.ir_wre;
    assign RegWre    = cw.reg_wre;
    assign RegDst    = cw.reg_dst;
    assign WrRegDSrc = cw.wr_reg_d_src;
    assign ALUSrcA   = cw.alu_src_a;
    assign ALUSrcB   = cw.alu_src_b;
    assign ALUOp     = cw.alu_op;
    assign ExtSel    = cw.ext_sel;
    assign mRD       = cw.m_rd;
    assign mWR       = cw.m_wr;
    assign DBDataSrc = cw.db_data_src;
    assign state_o   = state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed and random instruction streams
// compared cycle by cycle against an instruction-level reference model.
module tb_multi_cycle_ctrl;
    import ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       PCWre;
    logic [1:0] PCSrc;
    logic       IRWre;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic [2:0] ALUOp;
    logic       ExtSel;
    logic       mRD;
    logic       mWR;
    logic       DBDataSrc;
    logic [3:0] state_o;

    int total = 0;
    int bad   = 0;

    multi_cycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero      (zero),
        .PCWre     (PCWre),
        .PCSrc     (PCSrc),
        .IRWre     (IRWre),
        .RegWre    (RegWre),
        .RegDst    (RegDst),
        .WrRegDSrc (WrRegDSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ExtSel    (ExtSel),
        .mRD       (mRD),
        .mWR       (mWR),
        .DBDataSrc (DBDataSrc),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {state, PCWre, PCSrc, IRWre, RegWre, mWR, mRD, DBDataSrc}
    function automatic logic [31:0] main_vec();
        return 32'({state_o, PCWre, PCSrc, IRWre, RegWre, mWR, mRD, DBDataSrc});
    endfunction

    function automatic logic [31:0] mk_vec(input logic [3:0] st, input logic pcw,
                                           input logic [1:0] src, input logic ir,
                                           input logic rw, input logic mw,
                                           input logic mr, input logic db);
        return 32'({st, pcw, src, ir, rw, mw, mr, db});
    endfunction

    // Reference model: one instruction from IF (entered at posedge+1) to its retirement.
    task automatic run_instr(input logic [5:0] op, input logic z);
        logic [3:0] seq [5];
        int         lat;
        bit         rtype, ialu, is_lw, is_sw, is_br, taken, is_jal;
        logic [1:0] last_src;
        logic [2:0] aop;
        logic [1:0] e_dst;
        logic       e_pcw, e_ir, e_rw, e_mw, e_mr, e_db;
        logic [1:0] e_src;

        rtype  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_SLT);
        ialu   = (op == OP_ADDIU) || (op == OP_ORI);
        is_lw  = (op == OP_LW);
        is_sw  = (op == OP_SW);
        is_br  = (op == OP_BEQ) || (op == OP_BNE);
        is_jal = (op == OP_JAL);
        taken  = ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z);

        for (int i = 0; i < 5; i++) seq[i] = S_IF;
        seq[1] = S_ID;
        if (rtype || ialu) begin
            lat = 4; seq[2] = S_EXE_R; seq[3] = S_WB_R;
        end else if (is_lw) begin
            lat = 5; seq[2] = S_EXE_M; seq[3] = S_MEM; seq[4] = S_WB_L;
        end else if (is_sw) begin
            lat = 4; seq[2] = S_EXE_M; seq[3] = S_MEM;
        end else if (is_br) begin
            lat = 3; seq[2] = S_EXE_B;
        end else begin
            lat = 2;
        end

        if (taken)                           last_src = 2'b01;
        else if (op == OP_J || is_jal)       last_src = 2'b10;
        else if (op == OP_JR)                last_src = 2'b11;
        else                                 last_src = 2'b00;

        case (op)
            OP_SUB, OP_BEQ, OP_BNE: aop = 3'b001;
            OP_AND:                 aop = 3'b010;
            OP_ORI:                 aop = 3'b011;
            OP_SLT:                 aop = 3'b100;
            default:                aop = 3'b000;
        endcase
        e_dst = is_jal ? 2'b00 : (rtype ? 2'b10 : 2'b01);

        for (int k = 0; k < lat; k++) begin
            opcode = op;
            zero   = z;
            #3;
            e_pcw = (k == lat - 1);
            e_ir  = (k == 0);
            e_rw  = ((rtype || ialu || is_lw) && k == lat - 1) || (is_jal && k == 1);
            e_mw  = is_sw && (k == 3);
            e_mr  = is_lw && (k >= 3);
            e_db  = is_lw && (k == 4);
            e_src = (k == lat - 1) ? last_src : 2'b00;
            chk($sformatf("op%b_z%0d_c%0d", op, z, k), main_vec(),
                mk_vec(seq[k], e_pcw, e_src, e_ir, e_rw, e_mw, e_mr, e_db));
            if (e_rw)
                chk($sformatf("op%b_wbsel_c%0d", op, k), 32'({RegDst, WrRegDSrc}),
                    32'({e_dst, !is_jal}));
            if (k == 2)
                chk($sformatf("op%b_alu_c%0d", op, k),
                    32'({ALUSrcA, ALUSrcB, ExtSel, ALUOp}),
                    32'({1'b0, ialu && op == OP_ADDIU || op == OP_ORI || is_lw || is_sw,
                         op != OP_ORI, aop}));
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] defined_ops [13];
    logic [5:0] rop;

    initial begin
        defined_ops = '{OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ORI, OP_SLT, OP_SW,
                        OP_LW, OP_BEQ, OP_BNE, OP_J, OP_JR, OP_JAL};
        reset  = 1'b1;
        opcode = OP_ADD;
        zero   = 1'b0;

        // Reset holds S_IF with no writes.
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_state", 32'({state_o, PCWre, RegWre, mWR, mRD}),
                32'({S_IF, 1'b0, 1'b0, 1'b0, 1'b0}));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        run_instr(OP_ADD, 1'b0);
        run_instr(OP_LW, 1'b1);
        run_instr(OP_SW, 1'b0);
        run_instr(OP_BEQ, 1'b1);
        run_instr(OP_BEQ, 1'b0);
        run_instr(OP_BNE, 1'b1);
        run_instr(OP_BNE, 1'b0);
        run_instr(OP_JAL, 1'b0);
        run_instr(OP_J, 1'b1);
        run_instr(OP_JR, 1'b0);
        run_instr(OP_ORI, 1'b0);
        run_instr(6'b101010, 1'b0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rop = 6'($urandom);
                if (rop == OP_HALT) rop = 6'b101010;
            end else begin
                rop = defined_ops[$urandom_range(0, 12)];
            end
            run_instr(rop, 1'($urandom));
        end

        // Reset in the middle of SW execute: abandoned, no memory write.
        opcode = OP_SW;
        #3;
        chk("sw_abort_if", main_vec(), mk_vec(S_IF, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sw_abort_exe", 32'({state_o, mWR}), 32'({S_EXE_M, 1'b0}));
        reset = 1'b1;
        #1;
        chk("sw_abort_async", 32'({state_o, mWR, PCWre}), 32'({S_IF, 1'b0, 1'b0}));
        @(posedge clk); #1;
        chk("sw_abort_hold", 32'({state_o, mWR, PCWre}), 32'({S_IF, 1'b0, 1'b0}));
        reset = 1'b0;
        run_instr(OP_ADDIU, 1'b0);

        // HALT parks the FSM until reset.
        opcode = OP_HALT;
        #3;
        chk("halt_if", 32'({state_o, PCWre}), 32'({S_IF, 1'b0}));
        @(posedge clk); #1;
        chk("halt_id", 32'({state_o, PCWre}), 32'({S_ID, 1'b0}));
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            opcode = 6'($urandom);
            zero   = 1'($urandom);
            #3;
            chk($sformatf("halt_hold_%0d", i), 32'({state_o, PCWre, RegWre, mWR}),
                32'({S_HALT, 1'b0, 1'b0, 1'b0}));
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("halt_reset", 32'(state_o), 32'(S_IF));
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(6'b101010, 1'b1);
        run_instr(OP_SLT, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
